cpu_dbg_unit: RTL

CPU_DBG_UNIT -- requirements
Module: cpu_dbg_unit

---
 rtl/cpu_dbg_pkg.sv | 16 +
 rtl/sync_edge.sv | 28 ++
 rtl/cpu_dbg_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Debug-unit shared types: FSM state encoding and mode selector values.
// Imported by cpu_dbg_unit.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_BRK  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BRKPT = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports: clk, rst_n, d (async level in), rise (one-cycle pulse per 0->1).
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/cpu_dbg_unit.sv
// CPU debug unit: run-rate divider, run/step/breakpoint clock-enable FSM,
// enable counter and a channel display mux with auto-scan and freeze.
// Ports: clk_100M/reset_n; div_max, mode, step_btn, bp_addr, pc in;
// ch_data/ch_sel/auto_scan/freeze in; clk_en, halted, disp, disp_ch,
// en_count out.
module cpu_dbg_unit
  import cpu_dbg_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW     = 32,
  parameter int DIV_W  = 28,
  parameter int SCAN_W = 26
) (
  input  logic                    clk_100M,
  input  logic                    reset_n,
  input  logic [DIV_W-1:0]        div_max,
  input  logic [1:0]              mode,
  input  logic                    step_btn,
  input  logic [DW-1:0]           bp_addr,
  input  logic [DW-1:0]           pc,
  input  logic [NCH*DW-1:0]       ch_data,
  input  logic [$clog2(NCH)-1:0]  ch_sel,
  input  logic                    auto_scan,
  input  logic                    freeze,
  output logic                    clk_en,
  output logic                    halted,
  output logic [DW-1:0]           disp,
  output logic [$clog2(NCH)-1:0]  disp_ch,
  output logic [31:0]             en_count
);

  localparam int CW = $clog2(NCH);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             step_evt;
  state_t           state;
  state_t           state_d;
  logic             pulse_d;
  logic             bp_hit;

  // >= so that a div_max shrunk below the running count wraps at once
  assign tick = (div_cnt >= div_max);

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  sync_edge u_step_sync (
    .clk  (clk_100M),
    .rst_n(reset_n),
    .d    (step_btn),
    .rise (step_evt)
  );

  assign bp_hit = (mode == MODE_BRKPT) && tick && (pc == bp_addr);

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_HALT;
      clk_en <= 1'b0;
    end else begin
      state  <= state_d;
      clk_en <= pulse_d;
    end
  end

  // Mode changes take priority over a coincident step event.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_RUN: begin
        if (mode == MODE_HALT || mode == MODE_STEP)
          state_d = ST_HALT;
        else if (bp_hit)
          state_d = ST_BRK;
      end
      ST_HALT: begin
        if (mode == MODE_RUN || mode == MODE_BRKPT)
          state_d = ST_RUN;
      end
      ST_BRK: begin
        if (mode == MODE_HALT || mode == MODE_STEP)
          state_d = ST_HALT;
        else if (mode == MODE_RUN)
          state_d = ST_RUN;
        else if (step_evt)
          state_d = ST_RUN;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    pulse_d = 1'b0;
    unique case (state)
      ST_RUN: begin
        pulse_d = tick && !bp_hit &&
                  (mode == MODE_RUN || mode == MODE_BRKPT);
      end
      ST_HALT: begin
        pulse_d = step_evt &&
                  (mode == MODE_STEP || mode == MODE_HALT);
      end
      ST_BRK: begin
        pulse_d = step_evt && (mode == MODE_BRKPT);
      end
      default: pulse_d = 1'b0;
    endcase
  end

  assign halted = (state != ST_RUN);

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      en_count <= '0;
    end else if (clk_en) begin
      en_count <= en_count + 32'd1;
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [CW-1:0]     scan_idx;
  logic [CW-1:0]     idx;
  logic [DW-1:0]     sel_data;
  logic              freeze_q;

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) begin
        if (scan_idx == CW'(NCH - 1))
          scan_idx <= '0;
        else
          scan_idx <= scan_idx + 1'b1;
      end
    end
  end

  assign idx = auto_scan ? scan_idx : ch_sel;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(idx) == k)
        sel_data = ch_data[k*DW +: DW];
    end
  end

  // Update every cycle except while freeze has been high for >1 cycle,
  // so the rising edge itself captures the live channel.
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      freeze_q <= 1'b0;
      disp     <= '0;
      disp_ch  <= '0;
    end else begin
      freeze_q <= freeze;
      if (!(freeze && freeze_q)) begin
        disp    <= sel_data;
        disp_ch <= idx;
      end
    end
  end

endmodule
